// File: rtl/demux8_tdm.sv
// demux8_tdm: serial 8-slot TDM frame to parallel word.
// Slot 0 arrives first on a sync beat. Slots 1..7 follow on later beats.
// A completed frame is published on d with a one-cycle d_valid pulse.
// A partial frame is dropped with a one-cycle frame_err pulse, either on a
// premature sync or after TIMEOUT consecutive idle cycles.
module demux8_tdm #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       din,
  input  logic       sync,
  output logic [2:0] s,
  output logic [0:7] d,
  output logic       d_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {IDLE, COLLECT} state_t;

  // The idle count that, once one more idle cycle passes, reaches TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] idle_cnt;
  logic [0:6] slots;   // slot 7 is never stored; it goes straight into d
  logic       start, fill_last, timeout_hit;

  assign busy        = (state == COLLECT);
  assign start       = in_valid & sync;
  assign fill_last   = busy & in_valid & ~sync & (s == 3'd7);
  assign timeout_hit = busy & ~in_valid & (idle_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a sync beat opens a frame; the last slot or a timeout closes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (fill_last || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: slot capture, word publish, idle counting and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= 3'd0;
      d         <= 8'b0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      idle_cnt  <= 8'd0;
      slots     <= 7'b0;
    end else begin
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            slots    <= {din, 6'b0};
            s        <= 3'd1;
            idle_cnt <= 8'd0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            idle_cnt <= 8'd0;
            if (sync) begin
              // A sync beat mid-frame restarts the frame with this beat as slot 0.
              frame_err <= 1'b1;
              slots     <= {din, 6'b0};
              s         <= 3'd1;
            end else if (s == 3'd7) begin
              d       <= {slots, din};
              d_valid <= 1'b1;
              s       <= 3'd0;
            end else begin
              slots[s] <= din;
              s        <= s + 3'd1;
            end
          end else if (timeout_hit) begin
            frame_err <= 1'b1;
            s         <= 3'd0;
            idle_cnt  <= 8'd0;
            slots     <= 7'b0;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demux8_tdm.sv
// Testbench for demux8_tdm.
// Directed scenarios plus randomized traffic, checked against a
// queue-based frame model.
module tb_demux8_tdm;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [2:0] s;
  logic [0:7] d;
  logic       d_valid, frame_err, busy;

  demux8_tdm #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .sync(sync),
    .s(s), .d(d), .d_valid(d_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame being collected is a queue of received bits.
  bit         mq[$];
  int         m_idle = 0;
  logic [0:7] m_d = 8'b0;
  logic       m_dv = 1'b0;
  logic       m_err = 1'b0;

  logic [13:0] dut_vec;
  assign dut_vec = {s, d, d_valid, frame_err, busy};

  function automatic logic [13:0] exp_vec();
    return {3'(mq.size()), m_d, m_dv, m_err, (mq.size() > 0)};
  endfunction

  task automatic model_update(input logic v, input logic dn, input logic sy, input logic r);
    m_dv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      mq.delete();
      m_idle = 0;
      m_d    = 8'b0;
    end else if (v) begin
      m_idle = 0;
      if (sy) begin
        if (mq.size() > 0) m_err = 1'b1;
        mq.delete();
        mq.push_back(dn);
      end else if (mq.size() > 0) begin
        mq.push_back(dn);
        if (mq.size() == 8) begin
          for (int k = 0; k < 8; k++) m_d[k] = mq[k];
          m_dv = 1'b1;
          mq.delete();
        end
      end
    end else if (mq.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_err = 1'b1;
        mq.delete();
        m_idle = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model over the same edge, then settle.
  task automatic step(input logic v, input logic dn, input logic sy);
    in_valid = v;
    din      = dn;
    sync     = sy;
    @(posedge clk);
    model_update(v, dn, sy, rst);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_vec !== 14'b0) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", dut_vec, 14'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [0:7] pat = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i], i == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model beat=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (d !== 8'b10110010 || d_valid !== 1'b1 || busy !== 1'b0 || s !== 3'd0) begin
      errors++;
      $display("FAIL basic_word got d=%b dv=%b busy=%b s=%0d want d=10110010 dv=1 busy=0 s=0",
               d, d_valid, busy, s);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (d_valid !== 1'b0 || d !== 8'b10110010) begin
      errors++;
      $display("FAIL basic_pulse_width got dv=%b d=%b want dv=0 d=10110010", d_valid, d);
    end
  endtask

  task automatic test_gaps();
    logic [0:7] pat = 8'b10110010;
    int dv = 0, er = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i], i == 0);
      if (d_valid) dv++;
      if (frame_err) er++;
      checks++;
      if (s !== 3'((i + 1) % 8)) begin
        errors++;
        $display("FAIL gaps_slot beat=%0d got=%0d want=%0d", i, s, (i + 1) % 8);
      end
      if (i < 7) begin
        repeat (2) begin
          step(1'b0, 1'b0, 1'b0);
          if (d_valid) dv++;
          if (frame_err) er++;
          checks++;
          if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL gaps_model beat=%0d got=%h want=%h", i, dut_vec, exp_vec());
          end
        end
      end
    end
    checks++;
    if (dv != 1 || er != 0 || d !== 8'b10110010) begin
      errors++;
      $display("FAIL gaps_summary got dv=%0d err=%0d d=%b want dv=1 err=0 d=10110010", dv, er, d);
    end
  endtask

  task automatic test_resync();
    int dv = 0, er = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 5)       step(1'b1, 1'($urandom_range(0, 1)), i == 0);
      else if (i == 5) step(1'b1, 1'b1, 1'b1);
      else             step(1'b1, 1'b0, 1'b0);
      if (d_valid) dv++;
      if (frame_err) er++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL resync_model beat=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (er != 1 || dv != 1 || d !== 8'b10000000) begin
      errors++;
      $display("FAIL resync_summary got err=%0d dv=%0d d=%b want err=1 dv=1 d=10000000", er, dv, d);
    end
  endtask

  task automatic test_timeout();
    logic [0:7] d0 = d;
    int er = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i == 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (frame_err) er++;
      if (i == TIMEOUT - 1) begin
        checks++;
        if (busy !== 1'b1 || frame_err !== 1'b0 || s !== 3'd3) begin
          errors++;
          $display("FAIL timeout_early got busy=%b err=%b s=%0d want busy=1 err=0 s=3", busy, frame_err, s);
        end
      end
    end
    checks++;
    if (er != 1 || frame_err !== 1'b1 || busy !== 1'b0 || s !== 3'd0 || d !== d0) begin
      errors++;
      $display("FAIL timeout_abort got errs=%0d err=%b busy=%b s=%0d d=%b want errs=1 err=1 busy=0 s=0 d=%b",
               er, frame_err, busy, s, d, d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:15] pat = 16'hFF0F;
    int c1 = -1, c2 = -1;
    logic [0:7] w1 = 8'b0, w2 = 8'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step(1'b1, pat[i], (i % 8) == 0);
      else        step(1'b0, 1'b0, 1'b0);
      if (d_valid && c1 < 0)       begin c1 = i; w1 = d; end
      else if (d_valid && c2 < 0)  begin c2 = i; w2 = d; end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_model beat=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (c1 != 7 || c2 != 15 || w1 !== 8'b11111111 || w2 !== 8'b00001111) begin
      errors++;
      $display("FAIL b2b_words got c1=%0d c2=%0d w1=%b w2=%b want c1=7 c2=15 w1=11111111 w2=00001111",
               c1, c2, w1, w2);
    end
  endtask

  task automatic test_reset_mid();
    logic [0:7] pat = 8'h5A;
    int dv = 0, er = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec !== 14'b0) begin
      errors++;
      $display("FAIL rstmid_zero got=%h want=%h", dut_vec, 14'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) step(1'b1, pat[i], i == 0);
      else       step(1'b0, 1'b0, 1'b0);
      if (d_valid) dv++;
      if (frame_err) er++;
      if (i == 7) begin
        checks++;
        if (d !== 8'b01011010 || d_valid !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_word got d=%b dv=%b want d=01011010 dv=1", d, d_valid);
        end
      end
    end
    checks++;
    if (dv != 1 || er != 0) begin
      errors++;
      $display("FAIL rstmid_pulses got dv=%0d err=%0d want dv=1 err=0", dv, er);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      int r = int'($urandom_range(0, 99));
      rst = (r == 0);
      if ($urandom_range(0, 39) == 0) begin
        repeat (int'($urandom_range(10, 20))) begin
          step(1'b0, 1'b0, 1'b0);
          checks++;
          if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random_idle_model step=%0d got=%h want=%h", i, dut_vec, exp_vec());
          end
        end
      end
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 2));
      checks++;
      if (dut_vec !== exp_vec() || (d_valid && frame_err)) begin
        errors++;
        $display("FAIL random_model step=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_resync();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
